// File: rtl/ccip_if_pkg.sv
// CCI-P channel-1 write request types used by the HerQules ring writer.
`timescale 1ns/1ps
package ccip_if_pkg;

   typedef enum logic [1:0] {
      eVC_VA  = 2'd0,
      eVC_VL0 = 2'd1,
      eVC_VH0 = 2'd2,
      eVC_VH1 = 2'd3
   } t_ccip_vc;

   typedef enum logic [1:0] {
      eCL_LEN_1 = 2'd0,
      eCL_LEN_2 = 2'd1,
      eCL_LEN_4 = 2'd3
   } t_ccip_clLen;

   typedef enum logic [3:0] {
      eREQ_WRLINE_I = 4'h0,
      eREQ_WRLINE_M = 4'h1,
      eREQ_WRPUSH_I = 4'h2,
      eREQ_WRFENCE  = 4'h4,
      eREQ_INTR     = 4'h6
   } t_ccip_c1_req;

   typedef logic [41:0]  t_ccip_clAddr;
   typedef logic [15:0]  t_ccip_mdata;
   typedef logic [511:0] t_ccip_clData;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic         sop;
      t_ccip_clLen  cl_len;
      t_ccip_c1_req req_type;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

endpackage

// File: rtl/hq_fifo_writer.sv
// HerQules message writer: buffers 256-bit messages, packs two per cache line and
// writes the lines into a host ring buffer over CCI-P channel 1.
`timescale 1ns/1ps
module hq_fifo_writer
   import ccip_if_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned FLUSH_CYCLES = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [63:0]    wr_addr,
   input  logic [63:0]    wr_capacity,
   input  logic [255:0]   wr_msg,
   input  logic           wr_valid,
   output logic [63:0]    wr_drops,
   output logic [63:0]    wr_head,
   input  logic           c1TxAlmFull,
   output t_if_ccip_c1_Tx c1_sTx
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StHalf, StSend} state_e;

   logic [255:0]   mem_q [FIFO_DEPTH];
   logic [AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   state_e         state_q, state_d;
   logic [255:0]   slot0_q, slot0_d, slot1_q, slot1_d;
   logic [31:0]    timer_q, timer_d;
   logic [63:0]    drops_q, drops_d, head_q, head_d;
   logic [63:0]    addr_q, addr_d, cap_q, cap_d;
   t_if_ccip_c1_Tx tx_q, tx_d;

   logic           empty, full, push, cfg_ok, cfg_chg;
   logic [63:0]    head_base, head_inc;
   logic [255:0]   fifo_out;

   // Next-state logic for FIFO pointers, packer, drop counter, ring head and request
   always_comb begin
      empty     = (wptr_q == rptr_q);
      full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      push      = wr_valid && !full;
      fifo_out  = mem_q[rptr_q[AW-1:0]];
      cfg_ok    = (wr_addr != 64'd0) && (wr_capacity >= 64'd64);
      cfg_chg   = (wr_addr != addr_q) || (wr_capacity != cap_q);
      // A config change restarts the ring; a line sent this cycle already uses head 0
      head_base = cfg_chg ? 64'd0 : head_q;
      head_inc  = head_base + 64'd1;

      wptr_d    = push ? wptr_q + PtrOne : wptr_q;
      rptr_d    = rptr_q;
      state_d   = state_q;
      slot0_d   = slot0_q;
      slot1_d   = slot1_q;
      timer_d   = timer_q;
      drops_d   = drops_q;
      head_d    = head_base;
      addr_d    = wr_addr;
      cap_d     = wr_capacity;
      tx_d      = tx_q;
      tx_d.valid = 1'b0;

      if (wr_valid && full && (drops_q != '1)) begin
         drops_d = drops_q + 64'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (!empty && cfg_ok) begin
               rptr_d  = rptr_q + PtrOne;
               slot0_d = fifo_out;
               state_d = StHalf;
            end
         end
         StHalf: begin
            if (!empty && cfg_ok) begin
               rptr_d  = rptr_q + PtrOne;
               slot1_d = fifo_out;
               timer_d = 32'd0;
               state_d = StSend;
            end else if (FLUSH_CYCLES != 0) begin
               timer_d = timer_q + 32'd1;
               if (timer_q + 32'd1 == FLUSH_CYCLES) begin
                  slot1_d = '0;
                  timer_d = 32'd0;
                  state_d = StSend;
               end
            end
         end
         StSend: begin
            if (!c1TxAlmFull && cfg_ok) begin
               tx_d.valid        = 1'b1;
               tx_d.hdr.vc_sel   = eVC_VA;
               tx_d.hdr.sop      = 1'b1;
               tx_d.hdr.cl_len   = eCL_LEN_1;
               tx_d.hdr.req_type = eREQ_WRLINE_I;
               tx_d.hdr.address  = wr_addr[47:6] + head_base[41:0];
               tx_d.hdr.mdata    = head_base[15:0];
               tx_d.data         = {slot1_q, slot0_q};
               head_d  = ({head_inc[57:0], 6'd0} >= wr_capacity) ? 64'd0 : head_inc;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO storage carries no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= wr_msg;
      end
   end

   // State registers, all cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         state_q <= StIdle;
         slot0_q <= '0;
         slot1_q <= '0;
         timer_q <= '0;
         drops_q <= '0;
         head_q  <= '0;
         addr_q  <= '0;
         cap_q   <= '0;
         tx_q    <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         state_q <= state_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         timer_q <= timer_d;
         drops_q <= drops_d;
         head_q  <= head_d;
         addr_q  <= addr_d;
         cap_q   <= cap_d;
         tx_q    <= tx_d;
      end
   end

   assign wr_drops = drops_q;
   assign wr_head  = head_q;
   assign c1_sTx   = tx_q;

endmodule

// File: tb/tb_hq_fifo_writer.sv
// Self-checking bench for hq_fifo_writer: directed vector table, multi-cycle corner
// sequences and a randomized run against a message-order reference model.
`timescale 1ns/1ps
module tb_hq_fifo_writer;
   import ccip_if_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [63:0]    wr_addr = 64'd0;
   logic [63:0]    wr_capacity = 64'd0;
   logic [255:0]   wr_msg = '0;
   logic           wr_valid = 1'b0;
   logic [63:0]    wr_drops;
   logic [63:0]    wr_head;
   logic           c1TxAlmFull = 1'b0;
   t_if_ccip_c1_Tx c1_sTx;

   int checks = 0;
   int failures = 0;
   bit rand_bp = 1'b0;
   t_if_ccip_c1_Tx lines_q[$];

   typedef struct {
      logic [255:0] a;
      logic [255:0] b;
      logic [41:0]  addr;
      logic [15:0]  mdata;
      logic [63:0]  head;
   } vec_t;

   vec_t         vecs[8];
   logic [255:0] msgs[128];
   logic [255:0] c_msg, d_msg, e_msg;
   logic [63:0]  r_addr, r_cap;
   logic [41:0]  r_base;
   int           waited, r_lines, npairs;

   always #5 clk = ~clk;

   hq_fifo_writer #(.FIFO_DEPTH(16), .FLUSH_CYCLES(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_addr     (wr_addr),
      .wr_capacity (wr_capacity),
      .wr_msg      (wr_msg),
      .wr_valid    (wr_valid),
      .wr_drops    (wr_drops),
      .wr_head     (wr_head),
      .c1TxAlmFull (c1TxAlmFull),
      .c1_sTx      (c1_sTx)
   );

   // Line monitor: capture every emitted request
   always @(posedge clk) begin
      #1;
      if (c1_sTx.valid) lines_q.push_back(c1_sTx);
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
      if (rand_bp) c1TxAlmFull = ($urandom_range(0, 3) == 0);
   endtask

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [255:0] m);
      wr_msg   = m;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic expect_line(input string name, input logic [41:0] addr,
                              input logic [511:0] data, input logic [15:0] mdata,
                              input int budget, output int w);
      t_if_ccip_c1_Tx l;
      w = 0;
      while (lines_q.size() == 0 && w < budget) begin
         tick();
         w++;
      end
      if (lines_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: actual=no line required=line within %0d cycles", name, budget);
      end else begin
         l = lines_q.pop_front();
         check({name, "_addr"}, 512'(l.hdr.address), 512'(addr));
         check({name, "_data"}, l.data, data);
         check({name, "_mdata"}, 512'(l.hdr.mdata), 512'(mdata));
         check({name, "_hdr"}, 512'({l.hdr.req_type, l.hdr.vc_sel, l.hdr.cl_len, l.hdr.sop}),
               512'({eREQ_WRLINE_I, eVC_VA, eCL_LEN_1, 1'b1}));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      lines_q.delete();
      tick();
   endtask

   initial begin
      // Directed table: 8 pairs into a 4-line ring at 0x10000
      for (int i = 0; i < 8; i++) begin
         vecs[i].a     = {8{32'hAA00_0000 + 32'(i)}};
         vecs[i].b     = {8{32'hBB00_0000 + 32'(i)}};
         vecs[i].addr  = 42'h400 + 42'(i % 4);
         vecs[i].mdata = 16'(i % 4);
         vecs[i].head  = 64'((i + 1) % 4);
      end

      // Reset values while held in reset
      wr_addr     = 64'h1_0000;
      wr_capacity = 64'h100;
      tick();
      check("rst_drops", 512'(wr_drops), 512'd0);
      check("rst_head", 512'(wr_head), 512'd0);
      check("rst_valid", 512'(c1_sTx.valid), 512'd0);
      check("rst_hdr", 512'(c1_sTx.hdr), 512'd0);
      check("rst_data", c1_sTx.data, 512'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         push(vecs[i].a);
         push(vecs[i].b);
         expect_line($sformatf("vec%0d", i), vecs[i].addr, {vecs[i].b, vecs[i].a},
                     vecs[i].mdata, 20, waited);
         // Second push at N+1 gives valid at N+3: two ticks after the second push
         if (i == 0) check("pair_latency", 512'(waited), 512'd2);
         check($sformatf("vec%0d_head", i), 512'(wr_head), 512'(vecs[i].head));
         tick();
      end

      // Lone message flushes after the idle timeout with a zero upper slot
      c_msg = {8{32'hCC00_0001}};
      push(c_msg);
      expect_line("flush", 42'h400, {256'd0, c_msg}, 16'd0, 120, waited);
      checks++;
      if (waited < 63 || waited > 68) begin
         failures++;
         $display("FAIL flush_latency: actual=%0d required=63..68", waited);
      end
      check("flush_head", 512'(wr_head), 512'd1);
      d_msg = {8{32'hDD00_0001}};
      e_msg = {8{32'hEE00_0001}};
      push(d_msg);
      push(e_msg);
      expect_line("after_flush", 42'h401, {e_msg, d_msg}, 16'd1, 20, waited);
      check("after_flush_head", 512'(wr_head), 512'd2);
      tick();

      // Backpressure: 20 back-to-back messages, 16 in FIFO + 2 in slots, 2 dropped
      c1TxAlmFull = 1'b1;
      for (int i = 0; i < 20; i++) begin
         msgs[i] = {8{32'hC000_0000 + 32'(i)}};
         push(msgs[i]);
      end
      for (int i = 0; i < 5; i++) tick();
      check("bp_no_lines", 512'(lines_q.size()), 512'd0);
      check("bp_drops", 512'(wr_drops), 512'd2);
      c1TxAlmFull = 1'b0;
      for (int k = 0; k < 9; k++) begin
         expect_line($sformatf("bp_line%0d", k), 42'h400 + 42'((2 + k) % 4),
                     {msgs[2*k+1], msgs[2*k]}, 16'((2 + k) % 4), 40, waited);
      end
      check("bp_head", 512'(wr_head), 512'd3);
      check("bp_drops_final", 512'(wr_drops), 512'd2);

      // Asynchronous reset while a line is held in SEND
      c1TxAlmFull = 1'b1;
      push({8{32'hF000_0001}});
      push({8{32'hF000_0002}});
      for (int i = 0; i < 5; i++) tick();
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 512'(c1_sTx.valid), 512'd0);
      check("midrst_drops", 512'(wr_drops), 512'd0);
      check("midrst_head", 512'(wr_head), 512'd0);
      check("midrst_data", c1_sTx.data, 512'd0);
      tick();
      c1TxAlmFull = 1'b0;
      #3;
      rst_n = 1'b1;
      lines_q.delete();
      for (int i = 0; i < 100; i++) tick();
      check("midrst_no_stale", 512'(lines_q.size()), 512'd0);
      check("midrst_head_after", 512'(wr_head), 512'd0);

      // Ring disabled: messages buffer but nothing is written until an address appears
      wr_addr = 64'd0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         msgs[i] = {8{32'h0D00_0000 + 32'(i)}};
         push(msgs[i]);
      end
      for (int i = 0; i < 100; i++) tick();
      check("dis_no_lines", 512'(lines_q.size()), 512'd0);
      check("dis_drops", 512'(wr_drops), 512'd0);
      wr_addr = 64'h2_0000;
      expect_line("en_line0", 42'h800, {msgs[1], msgs[0]}, 16'd0, 20, waited);
      expect_line("en_line1", 42'h801, {256'd0, msgs[2]}, 16'd1, 120, waited);
      check("en_head", 512'(wr_head), 512'd2);

      // Randomized run: line k must hold messages 2k and 2k+1 at ring slot k mod size
      do_reset();
      r_addr  = {$urandom, $urandom} & ~64'h3F;
      if (r_addr == 64'd0) r_addr = 64'h40;
      r_lines = $urandom_range(1, 8);
      r_cap   = 64'(r_lines) * 64'd64;
      r_base  = 42'(r_addr >> 6);
      npairs  = 40;
      wr_addr     = r_addr;
      wr_capacity = r_cap;
      tick();
      tick();
      rand_bp = 1'b1;
      for (int p = 0; p < npairs; p++) begin
         msgs[2*p]   = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
         msgs[2*p+1] = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
         push(msgs[2*p]);
         push(msgs[2*p+1]);
         for (int g = 0; g < int'($urandom_range(4, 12)); g++) tick();
      end
      rand_bp = 1'b0;
      c1TxAlmFull = 1'b0;
      for (int k = 0; k < npairs; k++) begin
         expect_line($sformatf("rnd%0d", k), r_base + 42'(k % r_lines),
                     {msgs[2*k+1], msgs[2*k]}, 16'(k % r_lines), 200, waited);
      end
      check("rnd_drops", 512'(wr_drops), 512'd0);
      check("rnd_head", 512'(wr_head), 512'(npairs % r_lines));
      for (int i = 0; i < 10; i++) tick();
      check("rnd_no_extra", 512'(lines_q.size()), 512'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
